alu_dp_sequencer: RTL and testbench
===================================

Name: alu_dp_sequencer

Overview:
- Sequences ARMv4 data-processing operations through the shared ALU: accepts one operation per valid/ready handshake, evaluates its condition field against the architectural CNVZ flags register, and drives the ALU.
- Captures the ALU result and flags, then presents writeback to the register file with backpressure.
- Owns the flags register (CNVZ, C=bit3 … Z=bit0) and sits between decode and ALU/register-file writeback.

Parameters:
- WIDTH, 32, operand/result width; ALU instantiated with the same WIDTH.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  operation offered
- req_ready  out  1  sequencer can accept
- req_cond  in  4  ARM condition field
- req_op  in  4  ALUFUN opcode (0000 AND … 1111 MVN, ARM ordering)
- req_s  in  1  S bit, flag update request
- req_rd  in  4  destination register index
- req_a  in  WIDTH  operand A (Rn)
- req_b  in  WIDTH  operand B (shifted operand)
- alu_a  out  WIDTH  to ALU a
- alu_b  out  WIDTH  to ALU b
- alu_fun  out  4  to ALU ALUFUN
- alu_cnvzi  out  4  to ALU CNVZI; always equals flags_out
- alu_s  in  WIDTH  ALU result
- alu_cnvzo  in  4  ALU flags out
- wb_valid  out  1  writeback entry present
- wb_ready  in  1  consumer accepts writeback
- wb_we  out  1  register write enable for this entry
- wb_rd  out  4  destination index
- wb_data  out  WIDTH  result
- skipped  out  1  entry failed its condition
- flags_out  out  4  architectural CNVZ
- flags_wr_en  in  1  direct flags write (MSR-style)
- flags_wr_data  in  4  value for direct write

Behaviour:
- Reset (async, any state): state=IDLE; flags_out=0000; wb_valid=0; wb_we=0; skipped=0; wb_rd=0; wb_data=0; alu_a/alu_b/alu_fun=0; captured request registers cleared. req_ready=0 while rst=1.
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, capture cond/op/s/rd/a/b, go to EXEC.
  - flags_wr_en honoured only in IDLE: flags <= flags_wr_data at the edge. A request accepted in the same edge sees the new flags in EXEC.
- EXEC (exactly 1 cycle):
  - alu_a/alu_b/alu_fun driven from captured registers.
  - Condition pass computed from flags_out: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 never (fail).
  - At the edge: wb_data<=alu_s, wb_rd<=rd, skipped<=!pass, wb_we<=pass&(op[3:2]!=2'b10).
  - Flags <= alu_cnvzo iff pass&(s | op[3:2]==2'b10); TST/TEQ/CMP/CMN always update. Otherwise flags are held.
  - Go to WB. flags_wr_en ignored.
- WB:
  - wb_valid=1; wb_we/wb_rd/wb_data/skipped stable until handshake.
  - On wb_ready: wb_valid deasserts next cycle, go to IDLE.
  - req_ready=0; flags_wr_en ignored.
- Latency: accept edge t0 → EXEC cycle t0+1 → wb_valid high from t0+2. Max throughput is 1 op per 3 cycles; there is no back-to-back overlap.
- Failed condition: entry still passes through WB (wb_valid=1, wb_we=0, skipped=1), so the consumer sees one response per request. Flags unchanged.
- Outside EXEC, alu_* outputs hold their last values; no glitching to zero.
- Reset mid-EXEC or mid-WB: the op is discarded with no writeback; flags go to 0000.

Optional Feature:
- Macro ALU_SEQ_COND_EXEC_EN.
- Defined: condition evaluation as above.
- Undefined: req_cond ignored and every op is treated as AL (pass=1, skipped always 0); ports unchanged.

Test Plan:
- Reset: rst=1 mid-run → flags_out=0000, wb_valid=0, req_ready=0. Release → req_ready=1 next cycle.
- SUBS AL: a=5, b=5, op=0010, s=1, rd=3 → wb_valid at t0+2, wb_data=0, wb_we=1, wb_rd=3, flags_out=1001 after EXEC edge.
- CMP then ADDNE: CMP a=7, b=7 sets Z. Then ADD cond=0001 → wb_valid=1, wb_we=0, skipped=1, flags_out unchanged (1001). Same with the macro undefined → wb_we=1, skipped=0.
- Backpressure: ADD a=3, b=1, wb_ready=0 for 3 cycles → wb_valid held, wb_data=4 stable, req_ready=0, new req_valid not accepted. wb_ready=1 → IDLE next cycle.
- Flags write + accept same edge: flags_wr_data=0100 with MOV cond=MI (0100), b=9 → executes, wb_we=1, wb_data=9. Same with flags_wr_data=0000 → skipped=1.
- Reset during EXEC of ADDS → no wb_valid ever for that op, flags_out=0000, next request processed normally.

Source files
------------

// File: rtl/alu_dp_sequencer_if.sv
// Decode / ALU / writeback bundle for alu_dp_sequencer.
// slave  : the sequencer side
// master : the surrounding pipeline (decode, ALU, register file)
interface alu_dp_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_cond;
  logic [3:0]       req_op;
  logic             req_s;
  logic [3:0]       req_rd;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_fun;
  logic [3:0]       alu_cnvzi;
  logic [WIDTH-1:0] alu_s;
  logic [3:0]       alu_cnvzo;

  logic             wb_valid;
  logic             wb_ready;
  logic             wb_we;
  logic [3:0]       wb_rd;
  logic [WIDTH-1:0] wb_data;
  logic             skipped;

  logic [3:0]       flags_out;
  logic             flags_wr_en;
  logic [3:0]       flags_wr_data;

  modport slave (
    input  req_valid, req_cond, req_op, req_s, req_rd, req_a, req_b,
    output req_ready,
    output alu_a, alu_b, alu_fun, alu_cnvzi,
    input  alu_s, alu_cnvzo,
    output wb_valid, wb_we, wb_rd, wb_data, skipped,
    input  wb_ready,
    output flags_out,
    input  flags_wr_en, flags_wr_data
  );

  modport master (
    output req_valid, req_cond, req_op, req_s, req_rd, req_a, req_b,
    input  req_ready,
    input  alu_a, alu_b, alu_fun, alu_cnvzi,
    output alu_s, alu_cnvzo,
    input  wb_valid, wb_we, wb_rd, wb_data, skipped,
    output wb_ready,
    input  flags_out,
    output flags_wr_en, flags_wr_data
  );
endinterface

// File: rtl/alu_dp_sequencer.sv
// ARMv4 data-processing sequencer: accepts one op, runs it through the
// shared ALU, owns the CNVZ flags register (C=3 N=2 V=1 Z=0) and presents
// one writeback entry per request with backpressure.
//
// Optional build macro ALU_SEQ_COND_EXEC_EN: when defined the ARM condition
// field is evaluated against the flags; when undefined every op runs as AL.
//
// state | meaning
// IDLE  | ready for a request, direct flags write allowed
// EXEC  | one cycle: ALU driven from captured op, result and flags captured
// WB    | writeback entry held until the consumer takes it
module alu_dp_sequencer #(
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  alu_dp_sequencer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  state_t           state;
  logic [3:0]       flags;
  logic             req_ready_r;
  logic             cap_s;
  logic [3:0]       cap_rd;
  logic [WIDTH-1:0] alu_a_r;
  logic [WIDTH-1:0] alu_b_r;
  logic [3:0]       alu_fun_r;
  logic             wb_valid_r;
  logic             wb_we_r;
  logic [3:0]       wb_rd_r;
  logic [WIDTH-1:0] wb_data_r;
  logic             skipped_r;
  logic             pass;
  logic             is_cmp;

`ifdef ALU_SEQ_COND_EXEC_EN
  logic [3:0] cap_cond;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic c, n, v, z;
    c = f[3];
    n = f[2];
    v = f[1];
    z = f[0];
    case (cond)
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = !z;
      4'h2:    cond_pass = c;
      4'h3:    cond_pass = !c;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = !n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = !v;
      4'h8:    cond_pass = c && !z;
      4'h9:    cond_pass = !c || z;
      4'hA:    cond_pass = (n == v);
      4'hB:    cond_pass = (n != v);
      4'hC:    cond_pass = !z && (n == v);
      4'hD:    cond_pass = z || (n != v);
      4'hE:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  // condition field is latched alongside the rest of the request
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cap_cond <= 4'h0;
    else if (state == S_IDLE && bus.req_valid && req_ready_r)
      cap_cond <= bus.req_cond;
  end

  assign pass = cond_pass(cap_cond, flags);
`else
  assign pass = 1'b1;
`endif

  // TST/TEQ/CMP/CMN: flags only, never write the register file
  assign is_cmp = (alu_fun_r[3:2] == 2'b10);

  // sequencer FSM with all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      flags       <= 4'h0;
      req_ready_r <= 1'b0;
      cap_s       <= 1'b0;
      cap_rd      <= 4'h0;
      alu_a_r     <= '0;
      alu_b_r     <= '0;
      alu_fun_r   <= 4'h0;
      wb_valid_r  <= 1'b0;
      wb_we_r     <= 1'b0;
      wb_rd_r     <= 4'h0;
      wb_data_r   <= '0;
      skipped_r   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.flags_wr_en)
            flags <= bus.flags_wr_data;
          if (bus.req_valid && req_ready_r) begin
            cap_s       <= bus.req_s;
            cap_rd      <= bus.req_rd;
            alu_a_r     <= bus.req_a;
            alu_b_r     <= bus.req_b;
            alu_fun_r   <= bus.req_op;
            req_ready_r <= 1'b0;
            state       <= S_EXEC;
          end else begin
            req_ready_r <= 1'b1;
          end
        end
        S_EXEC: begin
          wb_data_r  <= bus.alu_s;
          wb_rd_r    <= cap_rd;
          skipped_r  <= !pass;
          wb_we_r    <= pass && !is_cmp;
          wb_valid_r <= 1'b1;
          if (pass && (cap_s || is_cmp))
            flags <= bus.alu_cnvzo;
          state <= S_WB;
        end
        S_WB: begin
          if (bus.wb_ready) begin
            wb_valid_r  <= 1'b0;
            req_ready_r <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_r;
  assign bus.alu_a     = alu_a_r;
  assign bus.alu_b     = alu_b_r;
  assign bus.alu_fun   = alu_fun_r;
  assign bus.alu_cnvzi = flags;
  assign bus.wb_valid  = wb_valid_r;
  assign bus.wb_we     = wb_we_r;
  assign bus.wb_rd     = wb_rd_r;
  assign bus.wb_data   = wb_data_r;
  assign bus.skipped   = skipped_r;
  assign bus.flags_out = flags;

endmodule

// File: tb/tb_alu_dp_sequencer.sv
// Bench for alu_dp_sequencer: directed vector table plus hand sequences for
// backpressure and reset in the middle of an operation. A behavioural ARM
// ALU sits on the alu_* side.
module tb_alu_dp_sequencer;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  alu_dp_sequencer_if #(.WIDTH(32)) bus ();

  alu_dp_sequencer #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural ALU; logical ops keep C and V from CNVZI
  always_comb begin
    logic [31:0] x, y, r;
    logic [32:0] sum;
    logic        cin, arith, c, v;
    x = bus.alu_a; y = bus.alu_b; cin = 1'b0; arith = 1'b0; r = '0; sum = '0;
    case (bus.alu_fun)
      4'h0, 4'h8: r = bus.alu_a & bus.alu_b;
      4'h1, 4'h9: r = bus.alu_a ^ bus.alu_b;
      4'h2, 4'hA: begin y = ~bus.alu_b; cin = 1'b1; arith = 1'b1; end
      4'h3:       begin x = bus.alu_b; y = ~bus.alu_a; cin = 1'b1; arith = 1'b1; end
      4'h4, 4'hB: arith = 1'b1;
      4'h5:       begin cin = bus.alu_cnvzi[3]; arith = 1'b1; end
      4'h6:       begin y = ~bus.alu_b; cin = bus.alu_cnvzi[3]; arith = 1'b1; end
      4'h7:       begin x = bus.alu_b; y = ~bus.alu_a; cin = bus.alu_cnvzi[3]; arith = 1'b1; end
      4'hC:       r = bus.alu_a | bus.alu_b;
      4'hD:       r = bus.alu_b;
      4'hE:       r = bus.alu_a & ~bus.alu_b;
      default:    r = ~bus.alu_b;
    endcase
    if (arith) begin
      sum = {1'b0, x} + {1'b0, y} + {32'b0, cin};
      r   = sum[31:0];
      c   = sum[32];
      v   = (x[31] == y[31]) && (r[31] != x[31]);
    end else begin
      c = bus.alu_cnvzi[3];
      v = bus.alu_cnvzi[1];
    end
    bus.alu_s     = r;
    bus.alu_cnvzo = {c, r[31], v, (r == 32'h0)};
  end

  typedef struct {
    logic [3:0]  cond;
    logic [3:0]  op;
    logic        s;
    logic [3:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic        wr;       // load pre into flags on the accept edge
    logic [3:0]  pre;      // flags seen during EXEC
    logic        pass;     // condition outcome with condition execution on
    logic [31:0] data;
    logic [3:0]  fl_pass;  // flags after EXEC if the op executes
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req_valid = 1'b0; bus.req_cond = 4'h0; bus.req_op = 4'h0; bus.req_s = 1'b0;
    bus.req_rd = 4'h0; bus.req_a = '0; bus.req_b = '0;
    bus.flags_wr_en = 1'b0; bus.flags_wr_data = 4'h0;
  endtask

  task automatic wait_ready(input string name);
    int guard;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk({name, "_ready_wait"}, {31'b0, bus.req_ready}, 32'h1);
  endtask

  // one full request/writeback; entered and left at a falling edge
  task automatic run_vec(input int i);
    vec_t  t;
    logic  pe;
    logic  exp_we;
    string nm;
    t  = vecs[i];
    nm = $sformatf("v%0d", i);
`ifdef ALU_SEQ_COND_EXEC_EN
    pe = t.pass;
`else
    pe = 1'b1;
`endif
    exp_we = pe && (t.op[3:2] != 2'b10);
    wait_ready(nm);
    bus.req_valid = 1'b1; bus.req_cond = t.cond; bus.req_op = t.op; bus.req_s = t.s;
    bus.req_rd = t.rd; bus.req_a = t.a; bus.req_b = t.b;
    bus.flags_wr_en = t.wr; bus.flags_wr_data = t.pre;
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    chk({nm, "_exec_wb_valid"}, {31'b0, bus.wb_valid}, 32'h0);
    chk({nm, "_exec_req_ready"}, {31'b0, bus.req_ready}, 32'h0);
    chk({nm, "_alu_a"}, bus.alu_a, t.a);
    chk({nm, "_alu_b"}, bus.alu_b, t.b);
    chk({nm, "_alu_fun"}, {28'b0, bus.alu_fun}, {28'b0, t.op});
    chk({nm, "_exec_flags"}, {28'b0, bus.flags_out}, {28'b0, t.pre});
    chk({nm, "_cnvzi"}, {28'b0, bus.alu_cnvzi}, {28'b0, t.pre});
    @(negedge clk);
    chk({nm, "_wb_valid"}, {31'b0, bus.wb_valid}, 32'h1);
    chk({nm, "_wb_data"}, bus.wb_data, t.data);
    chk({nm, "_wb_we"}, {31'b0, bus.wb_we}, {31'b0, exp_we});
    chk({nm, "_wb_rd"}, {28'b0, bus.wb_rd}, {28'b0, t.rd});
    chk({nm, "_skipped"}, {31'b0, bus.skipped}, {31'b0, !pe});
    chk({nm, "_flags"}, {28'b0, bus.flags_out}, {28'b0, (pe ? t.fl_pass : t.pre)});
    bus.wb_ready = 1'b1;
    @(posedge clk);
    #1 bus.wb_ready = 1'b0;
    @(negedge clk);
    chk({nm, "_wb_done"}, {31'b0, bus.wb_valid}, 32'h0);
    chk({nm, "_back_idle"}, {31'b0, bus.req_ready}, 32'h1);
  endtask

  initial begin
    logic seen;
    n_cmp = 0;
    n_err = 0;
    //               cond  op    s     rd    a             b             wr    pre   pass  data          fl_pass
    vecs[0]  = '{4'hE, 4'h2, 1'b1, 4'd3,  32'd5,        32'd5,        1'b1, 4'h0, 1'b1, 32'd0,        4'h9}; // SUBS
    vecs[1]  = '{4'hE, 4'hA, 1'b0, 4'd1,  32'd7,        32'd7,        1'b1, 4'h0, 1'b1, 32'd0,        4'h9}; // CMP
    vecs[2]  = '{4'h1, 4'h4, 1'b0, 4'd2,  32'd1,        32'd2,        1'b0, 4'h9, 1'b0, 32'd3,        4'h9}; // ADDNE
    vecs[3]  = '{4'h4, 4'hD, 1'b0, 4'd4,  32'd0,        32'd9,        1'b1, 4'h4, 1'b1, 32'd9,        4'h4}; // MOVMI
    vecs[4]  = '{4'h4, 4'hD, 1'b0, 4'd5,  32'd0,        32'd9,        1'b1, 4'h0, 1'b0, 32'd9,        4'h0}; // MOVMI
    vecs[5]  = '{4'hE, 4'h4, 1'b1, 4'd6,  32'hFFFFFFFF, 32'd1,        1'b1, 4'h0, 1'b1, 32'd0,        4'h9}; // ADDS
    vecs[6]  = '{4'hE, 4'h4, 1'b1, 4'd7,  32'h7FFFFFFF, 32'd1,        1'b1, 4'h0, 1'b1, 32'h80000000, 4'h6}; // ADDS
    vecs[7]  = '{4'hC, 4'h0, 1'b1, 4'd8,  32'hF0,       32'h3C,       1'b1, 4'h8, 1'b1, 32'h30,       4'h8}; // ANDSGT
    vecs[8]  = '{4'hB, 4'hB, 1'b0, 4'd9,  32'd1,        32'd1,        1'b1, 4'h4, 1'b1, 32'd2,        4'h0}; // CMNLT
    vecs[9]  = '{4'hF, 4'hC, 1'b1, 4'd10, 32'd1,        32'd2,        1'b1, 4'h4, 1'b0, 32'd3,        4'h0}; // ORRS nv
    vecs[10] = '{4'h8, 4'h2, 1'b0, 4'd11, 32'd10,       32'd3,        1'b1, 4'h8, 1'b1, 32'd7,        4'h8}; // SUBHI
    vecs[11] = '{4'h9, 4'h3, 1'b1, 4'd12, 32'd3,        32'd10,       1'b1, 4'h8, 1'b0, 32'd7,        4'h8}; // RSBSLS
    vecs[12] = '{4'h0, 4'h9, 1'b0, 4'd13, 32'd5,        32'd5,        1'b1, 4'h1, 1'b1, 32'd0,        4'h1}; // TEQEQ
    vecs[13] = '{4'hE, 4'hF, 1'b1, 4'd14, 32'd0,        32'd0,        1'b1, 4'h0, 1'b1, 32'hFFFFFFFF, 4'h4}; // MVNS
    vecs[14] = '{4'hE, 4'h6, 1'b1, 4'd15, 32'd5,        32'd3,        1'b1, 4'h0, 1'b1, 32'd1,        4'h8}; // SBCS
    vecs[15] = '{4'h6, 4'hE, 1'b0, 4'd0,  32'hFF,       32'h0F,       1'b1, 4'h2, 1'b1, 32'hF0,       4'h2}; // BICVS
    vecs[16] = '{4'h3, 4'h5, 1'b1, 4'd1,  32'd1,        32'd1,        1'b1, 4'h8, 1'b0, 32'd3,        4'h0}; // ADCSCC
    vecs[17] = '{4'hA, 4'h7, 1'b0, 4'd2,  32'd2,        32'd5,        1'b1, 4'h6, 1'b1, 32'd2,        4'h6}; // RSCGE

    rst = 1'b1;
    idle_inputs();
    bus.wb_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_flags", {28'b0, bus.flags_out}, 32'h0);
    chk("rst_wb_valid", {31'b0, bus.wb_valid}, 32'h0);
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'h0);
    chk("rst_wb_data", bus.wb_data, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_req_ready", {31'b0, bus.req_ready}, 32'h1);

    for (int i = 0; i < NV; i++)
      run_vec(i);

    // backpressure: ADD 3+1 held for three cycles while another op is offered
    wait_ready("bp");
    bus.req_valid = 1'b1; bus.req_cond = 4'hE; bus.req_op = 4'h4; bus.req_rd = 4'd7;
    bus.req_a = 32'd3; bus.req_b = 32'd1;
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 4'hD; bus.req_b = 32'd55; bus.req_cond = 4'hE;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp%0d_wb_valid", k), {31'b0, bus.wb_valid}, 32'h1);
      chk($sformatf("bp%0d_wb_data", k), bus.wb_data, 32'd4);
      chk($sformatf("bp%0d_req_ready", k), {31'b0, bus.req_ready}, 32'h0);
      chk($sformatf("bp%0d_alu_b", k), bus.alu_b, 32'd1);
      if (k < 3) @(negedge clk);
    end
    idle_inputs();
    bus.wb_ready = 1'b1;
    @(posedge clk);
    #1 bus.wb_ready = 1'b0;
    @(negedge clk);
    chk("bp_done_wb_valid", {31'b0, bus.wb_valid}, 32'h0);
    chk("bp_done_req_ready", {31'b0, bus.req_ready}, 32'h1);

    // reset during EXEC of ADDS: no writeback, flags cleared
    wait_ready("rx");
    bus.req_valid = 1'b1; bus.req_cond = 4'hE; bus.req_op = 4'h4; bus.req_s = 1'b1;
    bus.req_rd = 4'd9; bus.req_a = 32'd1; bus.req_b = 32'd1;
    bus.flags_wr_en = 1'b1; bus.flags_wr_data = 4'h8;
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    chk("rx_exec_flags", {28'b0, bus.flags_out}, 32'h8);
    rst = 1'b1;
    #1;
    chk("rx_flags", {28'b0, bus.flags_out}, 32'h0);
    chk("rx_wb_valid", {31'b0, bus.wb_valid}, 32'h0);
    chk("rx_req_ready", {31'b0, bus.req_ready}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.wb_valid) seen = 1'b1;
    end
    chk("rx_no_wb", {31'b0, seen}, 32'h0);
    chk("rx_flags_after", {28'b0, bus.flags_out}, 32'h0);
    run_vec(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
